// File: rtl/patp_pkg.sv
// Shared definitions for the PATP core: opcodes, ALU function codes and the
// control FSM state encoding.
package patp_pkg;

  // Instruction opcodes, held in ir[7:5]
  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_INC   = 3'b011;
  localparam logic [2:0] OP_DEC   = 3'b100;
  localparam logic [2:0] OP_CLR   = 3'b101;
  localparam logic [2:0] OP_JMP   = 3'b110;
  localparam logic [2:0] OP_BZ    = 3'b111;

  // ALU function codes, shared with the ALU instance in the core top
  localparam logic [1:0] ALU_CLR = 2'b00;
  localparam logic [1:0] ALU_INC = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_DEC = 2'b11;

  // Control sequencer states
  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_OPERAND = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_STORE   = 3'd4
  } ctrl_state_t;

  // ALU function for an ALU-class opcode; anything else maps to clear
  function automatic logic [1:0] alu_func_of(input logic [2:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_INC:  return ALU_INC;
      OP_DEC:  return ALU_DEC;
      default: return ALU_CLR;
    endcase
  endfunction

endpackage

// File: rtl/patp_control.sv
// PATP instruction sequencer: fetches and decodes 8-bit instructions, drives
// the ALU and the memory request port, and handles jumps and branch-on-zero.
//
// Memory handshake: mem_req/mem_we/mem_addr/mem_wdata are registered and held
// stable while mem_req is high; a transfer completes in any cycle where
// mem_req and mem_ack are both high (mem_ack with mem_req low is ignored).
// The request for the next state is computed from the next-state values so a
// memory state can be entered with mem_req already high (zero-wait capable).
module patp_control
  import patp_pkg::*;
#(
  parameter int               ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        alu_func,
  output logic [7:0]        alu_p,
  output logic [7:0]        alu_q,
  input  logic [7:0]        alu_result,
  input  logic              alu_zero,
  output logic [7:0]        acc,
  output logic [ADDR_W-1:0] pc,
  output logic              z_flag,
  output logic              instr_done
);

  ctrl_state_t       state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        opnd_q, opnd_d;
  logic              z_q, z_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              xfer;
  logic [2:0]        op;
  logic [ADDR_W-1:0] opnd_addr;

  assign op        = ir_q[7:5];
  assign opnd_addr = ir_q[ADDR_W-1:0];
  assign xfer      = req_q & mem_ack;

  // Next-state, datapath updates and per-state outputs
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    z_d        = z_q;
    instr_done = 1'b0;
    alu_func   = ALU_CLR;
    case (state_q)
      ST_FETCH: begin
        if (xfer) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (op)
          OP_LOAD, OP_ADD: state_d = ST_OPERAND;
          OP_STORE:        state_d = ST_STORE;
          OP_JMP: begin
            pc_d       = opnd_addr;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
          OP_BZ: begin
            if (z_q) pc_d = opnd_addr;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
          default:         state_d = ST_EXECUTE;
        endcase
      end
      ST_OPERAND: begin
        if (xfer) begin
          if (op == OP_LOAD) begin
            acc_d      = mem_rdata;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            opnd_d  = mem_rdata;
            state_d = ST_EXECUTE;
          end
        end
      end
      ST_EXECUTE: begin
        alu_func   = alu_func_of(op);
        acc_d      = alu_result;
        z_d        = alu_zero;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_STORE: begin
        if (xfer) begin
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Memory request for the state being entered
  always_comb begin
    req_d  = (state_d == ST_FETCH) || (state_d == ST_OPERAND) || (state_d == ST_STORE);
    we_d   = (state_d == ST_STORE);
    addr_d = (state_d == ST_FETCH) ? pc_d : ir_d[ADDR_W-1:0];
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      z_q     <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      z_q     <= z_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = acc_q;
  assign alu_p     = opnd_q;
  assign alu_q     = acc_q;
  assign acc       = acc_q;
  assign pc        = pc_q;
  assign z_flag    = z_q;

endmodule

// File: tb/tb_patp_control.sv
// Bench for patp_control: a memory responder with selectable ack latency, an
// ALU model, and an instruction-level reference interpreter feeding a queue of
// expected post-instruction state (opcode, pc, acc, z) and expected memory.
module tb_patp_control;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       mem_req, mem_we, mem_ack;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [1:0] alu_func;
  logic [7:0] alu_p, alu_q, alu_result;
  logic       alu_zero;
  logic [7:0] acc;
  logic [4:0] pc;
  logic       z_flag, instr_done;

  patp_control #(.ADDR_W(5), .RESET_PC(5'd0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_func(alu_func), .alu_p(alu_p), .alu_q(alu_q),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .acc(acc), .pc(pc), .z_flag(z_flag), .instr_done(instr_done)
  );

  // ALU beside the sequencer: 00 clear, 01 q+1, 10 q+p, 11 q-1
  always_comb begin
    case (alu_func)
      2'b00:   alu_result = 8'h00;
      2'b01:   alu_result = alu_q + 8'd1;
      2'b10:   alu_result = alu_q + alu_p;
      default: alu_result = alu_q - 8'd1;
    endcase
  end
  assign alu_zero = (alu_result == 8'h00);

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0]  mem  [32];
  logic [7:0]  mmem [32];
  logic [7:0]  prog [32];
  logic [16:0] exp_q [$];
  logic [16:0] pend_exp;
  int   lat_mode = 0;
  bit   stray_ack = 1'b0;
  bit   active = 1'b0;
  bit   pending = 1'b0;
  int   retired = 0;
  int   cyc = 0;
  int   waits = 0;
  bit   busy = 1'b0;
  int   wait_left = 0;
  logic [13:0] req_snap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  function automatic int base_lat(input logic [2:0] op);
    case (op)
      3'b110, 3'b111: return 2;
      3'b010:         return 4;
      default:        return 3;
    endcase
  endfunction

  function automatic int pick_lat();
    int r;
    case (lat_mode)
      0: return 0;
      1: return 3;
      2: begin
        r = $urandom_range(0, 2);
        return (r == 0) ? 0 : ((r == 1) ? 1 : 5);
      end
      default: return 100000;
    endcase
  endfunction

  // Reference interpreter: executes n instructions on mmem
  task automatic model_run(input int n);
    logic [4:0] mpc;
    logic [7:0] macc, ir;
    logic       mz;
    logic [2:0] op;
    logic [4:0] a;
    mpc = 5'd0; macc = 8'h00; mz = 1'b0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      ir  = mmem[mpc];
      mpc = mpc + 5'd1;
      op  = ir[7:5];
      a   = ir[4:0];
      case (op)
        3'd0: macc = mmem[a];
        3'd1: mmem[a] = macc;
        3'd2: begin macc = macc + mmem[a]; mz = (macc == 8'h00); end
        3'd3: begin macc = macc + 8'd1;    mz = (macc == 8'h00); end
        3'd4: begin macc = macc - 8'd1;    mz = (macc == 8'h00); end
        3'd5: begin macc = 8'h00;          mz = 1'b1; end
        3'd6: mpc = a;
        default: if (mz) mpc = a;
      endcase
      exp_q.push_back({op, mpc, macc, mz});
    end
  endtask

  // ---------------- memory responder and monitor ----------------
  always begin
    @(negedge clk);
    if (rst) begin
      busy    = 1'b0;
      mem_ack = 1'b0;
      cyc     = -1;
      waits   = 0;
    end else begin
      if (!mem_req) begin
        if (busy) begin
          check("req_held", {31'd0, mem_req}, 32'd1);
          busy = 1'b0;
        end
        mem_ack   = stray_ack;
        mem_rdata = 8'hEE;
      end else begin
        if (!busy) begin
          busy      = 1'b1;
          wait_left = pick_lat();
          req_snap  = {mem_we, mem_addr, mem_wdata};
        end else begin
          check("req_stable", {18'd0, mem_we, mem_addr, mem_wdata}, {18'd0, req_snap});
        end
        if (wait_left == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          if (mem_we) mem[mem_addr] = mem_wdata;
          busy = 1'b0;
        end else begin
          mem_ack = 1'b0;
          wait_left--;
          waits++;
        end
      end
    end
    #1;
    if (!rst) begin
      cyc++;
      if (pending) begin
        check("pc",  {27'd0, pc},     {27'd0, pend_exp[13:9]});
        check("acc", {24'd0, acc},    {24'd0, pend_exp[8:1]});
        check("z",   {31'd0, z_flag}, {31'd0, pend_exp[0]});
        pending = 1'b0;
        retired++;
      end
      if (active && instr_done) begin
        if (exp_q.size() == 0) begin
          check("extra_done", 32'd1, 32'd0);
        end else begin
          pend_exp = exp_q.pop_front();
          pending  = 1'b1;
          check("latency", 32'(cyc), 32'(base_lat(pend_exp[16:14]) + waits));
        end
        cyc   = 0;
        waits = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic run_prog(input int n, input int mode);
    int budget;
    for (int i = 0; i < 32; i++) mmem[i] = mem[i];
    model_run(n);
    lat_mode = mode;
    retired  = 0;
    pending  = 1'b0;
    @(posedge clk); #2 rst = 1'b0; active = 1'b1;
    budget = n * 40 + 50;
    for (int k = 0; k < budget && retired < n; k++) begin
      @(negedge clk); #3;
    end
    if (retired < n) check("timeout", 32'(retired), 32'(n));
    active = 1'b0;
    hold_reset();
    for (int i = 0; i < 32; i++) check($sformatf("mem%0d", i), {24'd0, mem[i]}, {24'd0, mmem[i]});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    mem_ack = 1'b0; mem_rdata = 8'h00;
    clear_mem();
    hold_reset();
    @(negedge clk); #2;
    check("rst_req",  {31'd0, mem_req},    32'd0);
    check("rst_we",   {31'd0, mem_we},     32'd0);
    check("rst_pc",   {27'd0, pc},         32'd0);
    check("rst_acc",  {24'd0, acc},        32'd0);
    check("rst_z",    {31'd0, z_flag},     32'd0);
    check("rst_done", {31'd0, instr_done}, 32'd0);
    check("rst_func", {30'd0, alu_func},   32'd0);

    // LOAD 10, ADD 11: 05 + FB -> 00 with Z
    clear_mem();
    mem[0] = 8'h0A; mem[1] = 8'h4B; mem[10] = 8'h05; mem[11] = 8'hFB;
    run_prog(2, 0);

    // CLR, DEC, STORE 12 with three wait cycles per access
    hold_reset(); clear_mem();
    mem[0] = 8'hA0; mem[1] = 8'h80; mem[2] = 8'h2C; mem[12] = 8'h33;
    run_prog(3, 1);

    // BZ taken after CLR, then not taken after INC
    hold_reset(); clear_mem();
    mem[0] = 8'hA0; mem[1] = 8'hE5; mem[5] = 8'h60; mem[6] = 8'hE0;
    run_prog(4, 0);

    // PC wrap: JMP 31, INC at 31 wraps to 0, repeat
    hold_reset(); clear_mem();
    mem[0] = 8'hDF; mem[31] = 8'h60;
    run_prog(5, 2);

    // Random programs, each run zero-wait and again with mixed latency
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
      hold_reset();
      for (int i = 0; i < 32; i++) mem[i] = prog[i];
      run_prog(40, 0);
      hold_reset();
      for (int i = 0; i < 32; i++) mem[i] = prog[i];
      run_prog(40, (r == 3) ? 1 : 2);
    end

    // Reset in the middle of a stalled fetch; a stray ack afterwards is ignored
    hold_reset(); clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h60;
    lat_mode = 0;
    @(posedge clk); #2 rst = 1'b0;
    repeat (8) @(posedge clk);
    #2 lat_mode = 3;
    repeat (6) @(posedge clk);
    @(negedge clk); #2;
    check("stall_req", {31'd0, mem_req}, 32'd1);
    check("stall_acc_nz", {31'd0, (acc != 8'h00)}, 32'd1);
    @(posedge clk); #2 rst = 1'b1; stray_ack = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk); #2;
    check("mid_req", {31'd0, mem_req}, 32'd0);
    check("mid_pc",  {27'd0, pc},      32'd0);
    check("mid_acc", {24'd0, acc},     32'd0);
    check("mid_z",   {31'd0, z_flag},  32'd0);
    stray_ack = 1'b0;
    @(negedge clk); #2;
    check("stray_ack_pc",  {27'd0, pc},      32'd0);
    check("stray_ack_req", {31'd0, mem_req}, 32'd1);
    hold_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/patp_control.md
Name: patp_control

Overview:
- Instruction sequencer for the PATP core; the driving end of the ALU's func/operand/zero interface.
- Fetches 8-bit instructions from a 32-word unified memory and decodes them.
- Issues ALU function codes with operands, writes the result back to the accumulator and latches the zero flag.
- Executes jumps and branch-on-zero. The ALU itself is a separate instance beside this block in the core top.

Parameters:
- ADDR_W, 5, memory address / PC width; opcode field is fixed at 3 bits, so the instruction operand field is ADDR_W bits.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  core clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  memory request; held until acknowledged.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  8  write data (the accumulator).
- mem_rdata  in  8  read data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion strobe.
- alu_func  out  2  00 clear, 01 q+1, 10 q+p, 11 q-1.
- alu_p  out  8  operand register.
- alu_q  out  8  accumulator.
- alu_result  in  8  ALU result, combinational.
- alu_zero  in  1  ALU zero flag, combinational.
- acc  out  8  accumulator, for debug/visibility.
- pc  out  ADDR_W  program counter.
- z_flag  out  1  latched zero flag.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=FETCH, pc=RESET_PC, acc=0, z_flag=0, ir=0, opnd=0.
  - mem_req=0, mem_we=0, instr_done=0.
  - Reset aborts any outstanding transaction. mem_req is low from the first cycle after the reset edge. A mem_ack arriving after reset is ignored.
- Instruction format: ir[7:5] is the opcode, ir[ADDR_W-1:0] is the address.
  - 000 LOAD: acc = mem[a].
  - 001 STORE: mem[a] = acc.
  - 010 ADD: acc = acc + mem[a].
  - 011 INC.
  - 100 DEC.
  - 101 CLR.
  - 110 JMP a.
  - 111 BZ a: pc=a if z_flag=1.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and stay stable until mem_ack is sampled high.
  - mem_ack may arrive in the same cycle mem_req first rises (zero-wait) or any number of cycles later.
  - mem_req deasserts in the cycle after mem_ack, unless the next state immediately issues a new request.
  - mem_ack while mem_req=0 is ignored.
- States:
  - FETCH: req read at pc. On ack: ir<=mem_rdata, pc<=pc+1 (wraps 31->0), go to DECODE.
  - DECODE:
    - LOAD/ADD go to OPERAND.
    - STORE goes to STORE.
    - INC/DEC/CLR go to EXECUTE.
    - JMP: pc<=a, instr_done, go to FETCH.
    - BZ: pc<=a if z_flag, else pc unchanged; instr_done, go to FETCH.
  - OPERAND: req read at a. On ack: LOAD sets acc<=mem_rdata, instr_done, go to FETCH (z_flag unchanged). ADD sets opnd<=mem_rdata, go to EXECUTE.
  - EXECUTE: alu_func driven from ir (ADD 10, INC 01, DEC 11, CLR 00). acc<=alu_result, z_flag<=alu_zero, instr_done, go to FETCH.
  - STORE: req write at a, wdata=acc. On ack: instr_done, go to FETCH.
- alu_func=00 outside EXECUTE. alu_q=acc and alu_p=opnd at all times.
- Arithmetic is 8-bit modulo with no carry flag: FF+1=00 and sets Z; 00-1=FF and clears Z.
- Only ALU instructions (ADD/INC/DEC/CLR) update z_flag.
- Latency at zero-wait memory:
  - JMP/BZ: 2 cycles.
  - INC/DEC/CLR: 3 cycles.
  - STORE: 3 cycles.
  - LOAD: 3 cycles.
  - ADD: 4 cycles.
  - Each memory wait cycle adds one cycle.

Decomposition:
- Shared package patp_pkg:
  - opcode localparams.
  - ALU func codes (ALU_CLR, ALU_INC, ALU_ADD, ALU_DEC), also used by the ALU.
  - control state encoding.
- No sub-module; a single FSM plus datapath registers. The ALU instance lives in the core top.

Test Plan:
- Reset mid-fetch with mem_ack held off, rst pulsed -> next cycle mem_req=0, pc=0, acc=0, z_flag=0; ack arriving afterwards ignored.
- Program LOAD 10 (mem[10]=05), ADD 11 (mem[11]=FB), zero-wait -> acc=00, z_flag=1; instr_done pulses at cycles 3 and 7 after reset release.
- CLR, DEC, STORE 12 -> acc=FF, z_flag=0 after DEC; write of FF to address 12 with mem_we=1; mem_addr/wdata stable across 3 wait cycles of delayed ack.
- BZ taken vs. not taken: z_flag=1 -> pc=target; z_flag=0 -> pc=BZ address+1; instr_done 2 cycles after fetch start.
- PC wrap: INC at address 31 -> next fetch at address 0; JMP 31 then pc=31 then fetch address 31.
- Variable ack latency (0,1,5 waits) on each state -> mem_req never drops before ack, never reasserts spuriously; final acc identical to the zero-wait run.
